// File: rtl/spart_rx.sv
// spart_rx: RS232 receiver, 8N1, 16x oversampling.
//   clk      system clock, all logic on its rising edge
//   rst      asynchronous active-low reset
//   br_cfg   baud select (00=4800, 01=9600, 10=19200, 11=38400)
//   rxd      serial line, idle high, asynchronous to clk
//   rd_ack   one-cycle acknowledge of the held byte
//   rx_data  last received byte
//   rda      received data available
//   ferr     framing error on the held byte
//   oerr     an unacknowledged byte was overwritten (sticky until ack)
//   busy     receiver is inside a frame
module spart_rx #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned DIV_4800    = 1302,
   parameter int unsigned DIV_9600    = 651,
   parameter int unsigned DIV_19200   = 326,
   parameter int unsigned DIV_38400   = 163
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] br_cfg,
   input  logic       rxd,
   input  logic       rd_ack,
   output logic [7:0] rx_data,
   output logic       rda,
   output logic       ferr,
   output logic       oerr,
   output logic       busy
);

   // Divisors up to 65535 are supported.
   localparam int unsigned CW = 16;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rxs;
   logic [CW-1:0]          sel_div;
   logic [CW-1:0]          div_q;
   logic [CW-1:0]          tick_cnt;
   logic                   tick;
   logic [3:0]             tck;
   logic [2:0]             bit_idx;
   logic [7:0]             shreg;
   logic                   wait_hi;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) sync_q <= '1;
      else      sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
   end

   assign rxs = sync_q[SYNC_STAGES-1];

   always_comb begin
      sel_div = CW'(DIV_9600);
      case (br_cfg)
         2'b00:   sel_div = CW'(DIV_4800);
         2'b01:   sel_div = CW'(DIV_9600);
         2'b10:   sel_div = CW'(DIV_19200);
         default: sel_div = CW'(DIV_38400);
      endcase
   end

   assign tick = (state != IDLE) && (tick_cnt == '0);
   assign busy = (state != IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         div_q    <= '0;
         tick_cnt <= '0;
         tck      <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
         wait_hi  <= 1'b0;
         rx_data  <= '0;
         rda      <= 1'b0;
         ferr     <= 1'b0;
         oerr     <= 1'b0;
      end else begin
         // Acknowledge; a byte completing in the same cycle overrides below.
         if (rd_ack && rda) begin
            rda  <= 1'b0;
            ferr <= 1'b0;
            oerr <= 1'b0;
         end

         case (state)
            IDLE: begin
               // After a frame whose stop sample was low (e.g. a break),
               // the line must return high before a new start is accepted.
               if (rxs) wait_hi <= 1'b0;
               if (!rxs && !wait_hi) begin
                  state    <= START;
                  div_q    <= sel_div;
                  tick_cnt <= sel_div - CW'(1);
                  tck      <= '0;
                  bit_idx  <= '0;
               end
            end
            default: begin
               if (tick) tick_cnt <= div_q - CW'(1);
               else      tick_cnt <= tick_cnt - CW'(1);

               if (tick) begin
                  case (state)
                     START: begin
                        if (tck == 4'd7) begin
                           tck   <= '0;
                           state <= rxs ? IDLE : DATA;
                        end else begin
                           tck <= tck + 4'd1;
                        end
                     end
                     DATA: begin
                        // tck wraps 15 -> 0, so STOP starts with tck cleared.
                        tck <= tck + 4'd1;
                        if (tck == 4'hF) begin
                           shreg   <= {rxs, shreg[7:1]};
                           bit_idx <= bit_idx + 3'd1;
                           if (bit_idx == 3'd7) state <= STOP;
                        end
                     end
                     default: begin
                        tck <= tck + 4'd1;
                        if (tck == 4'hF) begin
                           state   <= IDLE;
                           rx_data <= shreg;
                           rda     <= 1'b1;
                           ferr    <= ~rxs;
                           oerr    <= rda & ~rd_ack;
                           wait_hi <= ~rxs;
                        end
                     end
                  endcase
               end
            end
         endcase
      end
   end

endmodule

// File: doc/spart_rx.md
SPART_RX -- requirements
Module: spart_rx

Interface
REQ-001 The block SHALL provide parameter SYNC_STAGES, default 2, giving the number of rxd synchronizer flops (minimum 2).
REQ-002 The block SHALL provide parameter DIV_4800, default 1302, giving the 16x-tick divisor for br_cfg=00 at 100 MHz.
REQ-003 The block SHALL provide parameter DIV_9600, default 651, giving the divisor for br_cfg=01.
REQ-004 The block SHALL provide parameter DIV_19200, default 326, giving the divisor for br_cfg=10.
REQ-005 The block SHALL provide parameter DIV_38400, default 163, giving the divisor for br_cfg=11.
REQ-006 clk  input  1  single system clock, all logic on its rising edge.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 br_cfg  input  2  baud rate select.
REQ-009 rxd  input  1  RS232 receive serial line, idle high, asynchronous to clk.
REQ-010 rd_ack  input  1  one-cycle consumer acknowledge of the held byte.
REQ-011 rx_data  output  8  last received byte.
REQ-012 rda  output  1  received data available.
REQ-013 ferr  output  1  framing error on the held byte.
REQ-014 oerr  output  1  overrun: an unacknowledged byte was overwritten.
REQ-015 busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-016 rxd SHALL pass through SYNC_STAGES flops, reset to 1, before any use; rxs denotes the synchronized value.
REQ-017 Tick generator: down-counter reloads divisor-1 and pulses tick for one clk when it reaches 0.
REQ-018 The divisor SHALL be chosen from br_cfg and latched only on start detection; a br_cfg change mid-frame SHALL have no effect until the next frame.
REQ-019 FSM states SHALL be IDLE, START, DATA and STOP, with a 4-bit tick count and a 3-bit bit index.
REQ-020 IDLE: the first clk where rxs is 0 SHALL go to START, reload the tick counter and clear the tick count.
REQ-021 START: on the 8th tick (mid start bit), rxs=0 SHALL go to DATA with the tick count cleared; rxs=1 SHALL return to IDLE with no output change (false start).
REQ-022 DATA: on every 16th tick, rxs SHALL be shifted in LSB first; after bit index 7 is sampled, the FSM SHALL go to STOP.
REQ-023 STOP: on the 16th tick, rx_data SHALL load the shift register, rda SHALL set, ferr SHALL be set to NOT rxs, and the FSM SHALL return to IDLE.
REQ-024 These outputs SHALL update on the clk after the stop-sample tick, so total latency from the start edge is about 152 ticks plus synchronizer delay.
REQ-025 rd_ack with rda=1 SHALL clear rda, ferr and oerr on the next clk; rd_ack with rda=0 SHALL have no effect.
REQ-026 A byte that completes while rda=1 and rd_ack=0 SHALL overwrite rx_data, set oerr (sticky), keep rda=1 and update ferr.
REQ-027 A byte that completes in the same clk as rd_ack SHALL load rx_data and keep rda=1; oerr SHALL be cleared and not set.
REQ-028 rxs low for the whole frame (break) SHALL produce rx_data=0x00, ferr=1; the FSM SHALL then wait in IDLE until rxs has returned to 1 before a new start can be detected.

Reset
REQ-029 With rst=0, asynchronously: FSM=IDLE, rx_data=0x00, rda=0, ferr=0, oerr=0, busy=0, synchronizer=all 1s, tick counter=0, shift register=0.
REQ-030 Reset asserted mid-frame SHALL abandon the frame with no rda; after release, the block SHALL wait for a fresh falling edge.

Verification
REQ-031 br_cfg=01, frame 0xA5 with a valid stop bit -> rx_data=0xA5, rda=1, ferr=0, oerr=0 about 152x651 clks after the start edge; rd_ack then drops rda next clk.
REQ-032 rxd low for 3 ticks then high -> busy pulses, FSM returns to IDLE, rda stays 0.
REQ-033 Frame 0x3C with stop bit=0 -> rx_data=0x3C, rda=1, ferr=1.
REQ-034 Frames 0x11 then 0x22 with no rd_ack -> rx_data=0x22, rda=1, oerr=1; a second case with rd_ack coincident with the 0x22 completion -> oerr=0.
REQ-035 br_cfg=11, back-to-back frames 0x00 and 0xFF, with br_cfg switched to 00 during the second frame -> both bytes received correctly at 38400.
REQ-036 rst pulsed low at DATA bit 4 -> all outputs at reset values; the next full frame 0x5A is received correctly.
